// File: rtl/memsync_arbiter.sv
// memsync_arbiter: round-robin owner of the shared host-memory row-transfer channel.
// Grants one bank's cache sync at a time and stalls the memory model while any sync is pending.
//
// state   | meaning
// IDLE    | no grant; searching req upward from ptr+1
// ISSUE   | xfer_valid high for the granted bank, waiting for xfer_ready or withdrawal
// WAIT    | transfer accepted, sync held until xfer_done
// RELEASE | sync dropped for one cycle so the bank can clear its req
module memsync_arbiter #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int CNTWIDTH  = 16,
    localparam int IDXW     = BGWIDTH + BAWIDTH,
    localparam int BANKS    = 2 ** IDXW
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BANKS-1:0]           req,
    input  logic [BANKS*ADDRWIDTH-1:0] req_row,
    output logic [BANKS-1:0]           sync,
    output logic                       xfer_valid,
    output logic [BGWIDTH-1:0]         xfer_bg,
    output logic [BAWIDTH-1:0]         xfer_ba,
    output logic [ADDRWIDTH-1:0]       xfer_row,
    input  logic                       xfer_ready,
    input  logic                       xfer_done,
    output logic                       busy,
    output logic                       stall,
    output logic [CNTWIDTH-1:0]        sync_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]           state;
    logic [IDXW-1:0]      gidx;
    logic [IDXW-1:0]      ptr;
    logic [ADDRWIDTH-1:0] row_q;
    logic [CNTWIDTH-1:0]  cnt;

    logic                 found;
    logic [IDXW-1:0]      pick;
    logic [IDXW-1:0]      cand;
    logic                 granted;

    // Search starts just past the last serviced bank; BANKS is a power of two so the add wraps.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int k = 1; k <= BANKS; k++) begin
            cand = ptr + k[IDXW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '1;
            gidx  <= '0;
            row_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gidx  <= pick;
                        row_q <= req_row[pick*ADDRWIDTH +: ADDRWIDTH];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Acceptance wins over a same-cycle withdrawal; an abort keeps ptr so the search repeats.
                    if (xfer_ready) begin
                        state <= WAIT;
                    end else if (!req[gidx]) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (xfer_done) begin
                        state <= RELEASE;
                        if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    ptr   <= gidx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign granted = (state == ISSUE) || (state == WAIT);

    always_comb begin
        sync = '0;
        if (granted) begin
            sync[gidx] = 1'b1;
        end
    end

    assign xfer_valid = (state == ISSUE);
    assign xfer_bg    = gidx[IDXW-1:BAWIDTH];
    assign xfer_ba    = gidx[BAWIDTH-1:0];
    assign xfer_row   = row_q;
    assign busy       = (state != IDLE);
    assign stall      = (|req) || busy;
    assign sync_count = cnt;

endmodule

// File: tb/tb_memsync_arbiter.sv
// Bench for memsync_arbiter: directed stimulus pushes expected grants into a queue,
// a negedge monitor pops and checks each accepted transfer.
module tb_memsync_arbiter;

    localparam int BANKS = 16;
    localparam int AW    = 17;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [BANKS-1:0]      req = '0;
    logic [BANKS*AW-1:0]   req_row = '0;
    logic                  xfer_ready = 1'b0;
    logic                  xfer_done = 1'b0;

    logic [BANKS-1:0]      sync;
    logic                  xfer_valid;
    logic [1:0]            xfer_bg;
    logic [1:0]            xfer_ba;
    logic [AW-1:0]         xfer_row;
    logic                  busy;
    logic                  stall;
    logic [15:0]           sync_count;

    logic [BANKS-1:0]      sync2;
    logic                  xfer_valid2;
    logic [1:0]            xfer_bg2;
    logic [1:0]            xfer_ba2;
    logic [AW-1:0]         xfer_row2;
    logic                  busy2;
    logic                  stall2;
    logic [1:0]            sync_count2;

    memsync_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_row(req_row),
        .sync(sync), .xfer_valid(xfer_valid), .xfer_bg(xfer_bg), .xfer_ba(xfer_ba),
        .xfer_row(xfer_row), .xfer_ready(xfer_ready), .xfer_done(xfer_done),
        .busy(busy), .stall(stall), .sync_count(sync_count)
    );

    // Same stimulus, 2-bit counter to exercise saturation.
    memsync_arbiter #(.CNTWIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .req(req), .req_row(req_row),
        .sync(sync2), .xfer_valid(xfer_valid2), .xfer_bg(xfer_bg2), .xfer_ba(xfer_ba2),
        .xfer_row(xfer_row2), .xfer_ready(xfer_ready), .xfer_done(xfer_done),
        .busy(busy2), .stall(stall2), .sync_count(sync_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            bank;
        logic [AW-1:0] row;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   exp_cnt  = 0;
    int   sat_exp [5] = '{1, 2, 3, 3, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int b, input logic [AW-1:0] r);
        req_row[b*AW +: AW] = r;
    endtask

    task automatic push(input int b, input logic [AW-1:0] r);
        exp_t e;
        e.bank = b;
        e.row  = r;
        exp_q.push_back(e);
    endtask

    // Returns at a negedge where xfer_valid is high, or flags a timeout.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!xfer_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!xfer_valid) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s_timeout: xfer_valid stayed 0, required 1", name);
        end
    endtask

    // Wait for accept, pulse xfer_done done_delay cycles after it; returns in RELEASE.
    task automatic serve(input int done_delay);
        wait_valid("serve");
        step();
        repeat (done_delay - 1) step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        exp_cnt++;
    endtask

    always @(negedge clk) begin
        check("sync_onehot0", {31'd0, $onehot0(sync)}, 32'd1);
        if (reset_n && xfer_valid && xfer_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL grant_unexpected: got bank %0d, required no grant", {xfer_bg, xfer_ba});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("grant_bg",   {30'd0, xfer_bg}, e.bank >> 2);
                check("grant_ba",   {30'd0, xfer_ba}, e.bank & 3);
                check("grant_row",  {15'd0, xfer_row}, {15'd0, e.row});
                check("grant_sync", {16'd0, sync}, 32'd1 << e.bank);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values; stall follows req even in reset
        reset_n = 1'b0;
        repeat (2) step();
        req = 16'h0010;
        @(negedge clk);
        check("rst_stall_req",  {31'd0, stall}, 32'd1);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_sync",       {16'd0, sync}, 32'd0);
        check("rst_valid",      {31'd0, xfer_valid}, 32'd0);
        check("rst_count",      {16'd0, sync_count}, 32'd0);
        check("rst_bgba",       {28'd0, xfer_bg, xfer_ba}, 32'd0);
        check("rst_row",        {15'd0, xfer_row}, 32'd0);
        step();
        req = '0;
        @(negedge clk);
        check("rst_stall_idle", {31'd0, stall}, 32'd0);
        step();

        // Single sync of bank 0, done 3 cycles after accept
        reset_n = 1'b1;
        req = 16'h0001;
        set_row(0, 17'h1ABCD);
        xfer_ready = 1'b1;
        push(0, 17'h1ABCD);
        @(negedge clk);
        check("t1_c0_valid", {31'd0, xfer_valid}, 32'd0);
        step();
        @(negedge clk);
        check("t1_c1_valid", {31'd0, xfer_valid}, 32'd1);
        check("t1_c1_sync",  {16'd0, sync}, 32'h0001);
        check("t1_c1_row",   {15'd0, xfer_row}, 32'h1ABCD);
        check("t1_c1_busy",  {31'd0, busy}, 32'd1);
        step();
        set_row(0, 17'h00555);
        @(negedge clk);
        check("t1_wait_valid", {31'd0, xfer_valid}, 32'd0);
        check("t1_wait_sync",  {16'd0, sync}, 32'h0001);
        check("t1_wait_row",   {15'd0, xfer_row}, 32'h1ABCD);
        step();
        step();
        xfer_done = 1'b1;
        @(negedge clk);
        check("t1_done_cnt", {16'd0, sync_count}, 32'd0);
        step();
        xfer_done = 1'b0;
        req = '0;
        @(negedge clk);
        check("t1_rel_sync", {16'd0, sync}, 32'd0);
        check("t1_rel_busy", {31'd0, busy}, 32'd1);
        check("t1_rel_cnt",  {16'd0, sync_count}, 32'd1);
        step();
        @(negedge clk);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_row",  {15'd0, xfer_row}, 32'h1ABCD);

        // All banks requesting from reset: grants 0..15 then 0
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < BANKS; i++) set_row(i, 17'h100 + 17'(i));
        req = '1;
        for (int i = 0; i < BANKS; i++) push(i, 17'h100 + 17'(i));
        push(0, 17'h100);
        for (int i = 0; i <= BANKS; i++) begin
            serve(1);
            @(negedge clk);
            check("t2_stall", {31'd0, stall}, 32'd1);
            if (i == BANKS) req = '0;
        end
        step();
        @(negedge clk);
        check("t2_count", {16'd0, sync_count}, exp_cnt);

        // ptr moved to 5, then banks 3 and 9: 9 wins, then 3
        req = 16'h0020;
        push(5, 17'h105);
        serve(2);
        req = 16'h0208;
        push(9, 17'h109);
        push(3, 17'h103);
        serve(1);
        req = 16'h0008;
        serve(1);
        req = '0;
        step();

        // Withdrawal in ISSUE aborts with ptr kept (ptr=3 -> bank 4 retried first)
        xfer_ready = 1'b0;
        req = 16'h0010;
        wait_valid("t4_issue");
        step();
        req = '0;
        step();
        @(negedge clk);
        check("t4_abort_valid", {31'd0, xfer_valid}, 32'd0);
        check("t4_abort_busy",  {31'd0, busy}, 32'd0);
        check("t4_abort_sync",  {16'd0, sync}, 32'd0);
        check("t4_abort_cnt",   {16'd0, sync_count}, exp_cnt);
        xfer_ready = 1'b1;
        req = 16'h0050;
        push(4, 17'h104);
        push(6, 17'h106);
        serve(1);
        req = 16'h0040;
        serve(1);
        req = '0;

        // Withdrawal in WAIT is ignored: transfer completes and counts
        step();
        req = 16'h0080;
        push(7, 17'h107);
        wait_valid("t4_wait");
        step();
        req = '0;
        step();
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("t4_waitdrop_cnt",  {16'd0, sync_count}, exp_cnt);
        check("t4_waitdrop_sync", {16'd0, sync}, 32'd0);
        step();
        @(negedge clk);
        check("t4_waitdrop_busy", {31'd0, busy}, 32'd0);

        // Reset during WAIT, late xfer_done ignored
        req = 16'h0002;
        push(1, 17'h101);
        wait_valid("t5");
        step();
        reset_n = 1'b0;
        req = '0;
        step();
        @(negedge clk);
        check("t5_rst_sync",  {16'd0, sync}, 32'd0);
        check("t5_rst_valid", {31'd0, xfer_valid}, 32'd0);
        check("t5_rst_busy",  {31'd0, busy}, 32'd0);
        check("t5_rst_cnt",   {16'd0, sync_count}, 32'd0);
        check("t5_rst_bgba",  {28'd0, xfer_bg, xfer_ba}, 32'd0);
        check("t5_rst_row",   {15'd0, xfer_row}, 32'd0);
        reset_n = 1'b1;
        exp_cnt = 0;
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        @(negedge clk);
        check("t5_late_done_cnt",  {16'd0, sync_count}, 32'd0);
        check("t5_late_done_busy", {31'd0, busy}, 32'd0);

        // Saturation on the 2-bit counter; spurious done in IDLE ignored
        req = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            push(0, 17'h100);
            serve(1);
            if (i == 4) req = '0;
            @(negedge clk);
            check("t6_cnt16", {16'd0, sync_count}, exp_cnt);
            check("t6_cnt2",  {30'd0, sync_count2}, sat_exp[i]);
        end
        step();
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        @(negedge clk);
        check("t6_spur_cnt16", {16'd0, sync_count}, 32'd5);
        check("t6_spur_cnt2",  {30'd0, sync_count2}, 32'd3);
        check("t6_spur_busy",  {31'd0, busy}, 32'd0);

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
